btn_event: RTL and testbench
============================

Name: btn_event

Overview:
- Sits downstream of each per-button debouncer in the slot machine front panel.
- Consumes a debounced button level and turns it into discrete user events:
  - a single-cycle press pulse,
  - a single-cycle release pulse,
  - auto-repeat pulses while the button is held.
- Downstream control logic (bet up/down, spin) consumes events only, never raw levels.

Parameters:
TICK_DIV, 100000, clk cycles per timing tick (1 kHz at 100 MHz)
HOLD_TICKS, 500, ticks a press must be held before the first repeat pulse
REPEAT_TICKS, 100, ticks between successive repeat pulses after the first

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
db  input  1  debounced button level, 1 = pressed; treated as asynchronous
press  output  1  one-cycle pulse on each accepted press
release  output  1  one-cycle pulse on each release
repeat  output  1  one-cycle pulse per auto-repeat event
held  output  1  level, 1 while the FSM is not IDLE
long_press  output  1  level, 1 from the first repeat pulse until release

Behaviour:
- Reset:
  - Asynchronous assertion; all flops clear.
  - Outputs press, release, repeat, held, long_press = 0.
  - FSM = IDLE; tick counter = 0; synchronizer and edge flops = 0.
  - Reset asserted mid-press drops every output immediately.
  - After deassertion with db already high, a rise is still detected (edge flops reset to 0): one press pulse follows.
- Input path:
  - db passes through a 2-flop synchronizer (s1, s2), then a prev register.
  - rise = s2 & ~prev; fall = ~s2 & prev.
- Tick prescaler:
  - Free-running counter 0..TICK_DIV-1, never restarted by button activity.
  - tick = 1 for the one cycle where counter == TICK_DIV-1; counter then wraps to 0.
  - Counter width = clog2(TICK_DIV).
- FSM states: IDLE, WAIT_HOLD, REPEATING. All outputs registered.
- IDLE:
  - On rise: press=1 for one cycle, hold_cnt=0, go to WAIT_HOLD.
- WAIT_HOLD:
  - Each tick: hold_cnt++.
  - On the tick where hold_cnt == HOLD_TICKS-1: repeat=1, long_press=1, rep_cnt=0, go to REPEATING.
- REPEATING:
  - Each tick: rep_cnt++.
  - On the tick where rep_cnt == REPEAT_TICKS-1: repeat=1, rep_cnt=0.
- Fall in WAIT_HOLD or REPEATING:
  - release=1 for one cycle; long_press=0; go to IDLE; counters cleared.
  - Fall has priority over a tick in the same cycle: no repeat pulse in the release cycle.
- held = 1 in WAIT_HOLD and REPEATING.
- Latency: db rising before clk edge 0 → press high after edge 2, low after edge 3. Release has the same 3-edge latency.
- First repeat timing:
  - Arrives HOLD_TICKS ticks after entry to WAIT_HOLD.
  - Tick phase is free-running, so this falls between (HOLD_TICKS-1)*TICK_DIV+1 and HOLD_TICKS*TICK_DIV cycles after press.
- Saturation and overlap:
  - hold_cnt and rep_cnt never exceed their terminal values.
  - press, release and repeat are never high in the same cycle.
- Short press (fall before the first hold tick terminal): press, then release; no repeat.
- db glitches shorter than one clk cycle may be missed. db is guaranteed debounced, so this is acceptable.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2.
- Reset with db=0 → all outputs 0; release rst_n, hold db=0 for 50 cycles → no pulses, held=0.
- db 0→1 before edge 0, held 5 cycles, then 0 → press=1 exactly after edge 2 for one cycle; held=1 until release; release pulse 3 edges after the fall; repeat never asserted.
- db held high 60 cycles → first repeat 9–12 cycles after press; later repeats exactly every 8 cycles; long_press=1 from the first repeat; on the fall, release pulse, long_press=0, held=0.
- Force fall to reach the FSM in the same cycle as a terminal tick in REPEATING → release=1, repeat=0 that cycle, state IDLE.
- Assert rst_n=0 while in REPEATING with db high → outputs 0 asynchronously. Deassert with db still high → exactly one press pulse 3 edges later, then normal hold timing.
- Pulse-exclusivity checker over a 10k-cycle random db stream (min level length 3 cycles):
  - press, release and repeat are mutually exclusive;
  - press and release counts alternate and differ by at most 1.

Source files
------------

// File: rtl/btn_event_if.sv
// Button event bundle between the front-panel button path and its consumers.
//   db          : debounced button level, 1 = pressed (asynchronous to clk)
//   press       : one-cycle pulse on each accepted press
//   release_evt : one-cycle pulse on each release
//   repeat_evt  : one-cycle pulse per auto-repeat event
//   held        : level, 1 while a press is being tracked
//   long_press  : level, 1 from the first repeat pulse until release
// The release/repeat events carry an _evt suffix because the bare words are
// SystemVerilog keywords.
// master : panel/consumer side (drives db, receives events)
// slave  : btn_event side (receives db, drives events)
interface btn_event_if;
  logic db;
  logic press;
  logic release_evt;
  logic repeat_evt;
  logic held;
  logic long_press;

  modport master (
    output db,
    input  press, release_evt, repeat_evt, held, long_press
  );

  modport slave (
    input  db,
    output press, release_evt, repeat_evt, held, long_press
  );
endinterface

// File: rtl/btn_event.sv
// Turns a debounced button level into discrete press / release / auto-repeat
// events for the slot machine front panel.
// Ports:
//   clk   : system clock, all state on the rising edge
//   rst_n : asynchronous active-low reset, clears every flop
//   bus   : btn_event_if.slave (db in; press, release_evt, repeat_evt,
//           held, long_press out)
// Parameters:
//   TICK_DIV     : clk cycles per timing tick
//   HOLD_TICKS   : ticks a press must be held before the first repeat
//   REPEAT_TICKS : ticks between successive repeats after the first
module btn_event #(
  parameter int TICK_DIV     = 100000,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  btn_event_if.slave  bus
);

  localparam int TDW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int RW  = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  localparam logic [TDW-1:0] TICK_LAST = TDW'(TICK_DIV - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0]  REP_LAST  = RW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEATING = 2'd2
  } state_t;

  // Input stage: db_p0/db_p1 form the 2-flop synchronizer, db_p2 is the
  // previous synchronized level used for edge detection.
  logic db_p0, db_p1, db_p2;
  logic rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_p0 <= 1'b0;
      db_p1 <= 1'b0;
      db_p2 <= 1'b0;
    end else begin
      db_p0 <= bus.db;
      db_p1 <= db_p0;
      db_p2 <= db_p1;
    end
  end

  assign rise = db_p1 & ~db_p2;
  assign fall = ~db_p1 & db_p2;

  // Free-running prescaler; button activity never restarts it, so the first
  // repeat lands anywhere within one tick period of its nominal time.
  logic [TDW-1:0] tick_cnt;
  logic           tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Event FSM: state, counters and every event output are registered.
  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [RW-1:0]   rep_q, rep_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;
  logic            rpt_q, rpt_d;
  logic            long_q, long_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rep_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    long_d  = long_q;

    // A fall outranks a tick arriving in the same cycle, so the release
    // cycle never carries a repeat pulse.
    if (state_q != IDLE && fall) begin
      rel_d   = 1'b1;
      long_d  = 1'b0;
      hold_d  = '0;
      rep_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          long_d = 1'b0;
          hold_d = '0;
          rep_d  = '0;
          if (rise) begin
            press_d = 1'b1;
            state_d = WAIT_HOLD;
          end
        end
        WAIT_HOLD: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              rpt_d   = 1'b1;
              long_d  = 1'b1;
              hold_d  = '0;
              rep_d   = '0;
              state_d = REPEATING;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        REPEATING: begin
          if (tick) begin
            if (rep_q == REP_LAST) begin
              rpt_d = 1'b1;
              rep_d = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.press       = press_q;
  assign bus.release_evt = rel_q;
  assign bus.repeat_evt  = rpt_q;
  assign bus.held        = (state_q != IDLE);
  assign bus.long_press  = long_q;

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event with TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2.
// Output vector order everywhere: {press, release_evt, repeat_evt, held, long_press}.
module tb_btn_event;
  localparam int TICK_DIV     = 4;
  localparam int HOLD_TICKS   = 3;
  localparam int REPEAT_TICKS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_event_if bif();

  btn_event #(
    .TICK_DIV    (TICK_DIV),
    .HOLD_TICKS  (HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  logic [4:0] o;
  assign o = {bif.press, bif.release_evt, bif.repeat_evt, bif.held, bif.long_press};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       db;
    logic [4:0] exp;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: through the active edge, then to the sampling (falling) edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic db, input logic [4:0] exp, input int n);
    for (int k = 0; k < n; k++) tv.push_back('{db, exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz, w, d, last, cyc, nrep, lp_bad;
    int excl_viol, alt_viol, long_viol, pc, rc, rptc, last_ev, ncyc, len;

    // Short press (edges counted from the first edge where db=1 is seen;
    // ticks are consumed at relative edges 3, 7, 11, ...).
    add(1'b1, 5'b00000, 2);   // j0..j1 synchronizer filling
    add(1'b1, 5'b10010, 1);   // j2 press, held
    add(1'b1, 5'b00010, 2);   // j3..j4
    add(1'b0, 5'b00010, 2);   // j5..j6 fall in flight
    add(1'b0, 5'b01000, 1);   // j7 release (tick same cycle, hold not terminal)
    add(1'b0, 5'b00000, 4);   // j8..j11
    // Long press, exact tick phase.
    add(1'b1, 5'b00000, 2);   // j12..j13
    add(1'b1, 5'b10010, 1);   // j14 press
    add(1'b1, 5'b00010, 8);   // j15..j22 hold ticks at j15, j19
    add(1'b1, 5'b00111, 1);   // j23 third tick: first repeat, long_press
    add(1'b1, 5'b00011, 7);   // j24..j30
    add(1'b1, 5'b00111, 1);   // j31 second repeat
    add(1'b1, 5'b00011, 2);   // j32..j33

    // Reset with db low.
    bif.db = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(o), 0);

    // Idle for 52 cycles: tick phase stays aligned for the table below.
    rst_n = 1'b1;
    nz = 0;
    for (int i = 0; i < 52; i++) begin
      step();
      if (o != 5'b00000) nz++;
    end
    chk("idle_no_activity", nz, 0);

    for (int i = 0; i < tv.size(); i++) begin
      bif.db = tv[i].db;
      step();
      chk($sformatf("vec%0d", i), int'(o), int'(tv[i].exp));
    end

    // Keep holding: repeats every 8 cycles, long_press/held stay high.
    cyc = 33; last = 31; nrep = 0; lp_bad = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      cyc++;
      if (bif.long_press !== 1'b1 || bif.held !== 1'b1 || bif.press || bif.release_evt) lp_bad++;
      if (bif.repeat_evt) begin
        chk("repeat_interval", cyc - last, 8);
        last = cyc;
        nrep++;
      end
    end
    chk("repeat_count", nrep, 4);
    chk("long_hold_levels", lp_bad, 0);

    // Fall arriving with a terminal repeat tick: release wins.
    w = 0;
    do begin step(); w++; end while (!bif.repeat_evt && w < 16);
    chk("prio_repeat_found", int'(bif.repeat_evt), 1);
    for (int i = 0; i < 5; i++) step();
    bif.db = 1'b0;
    step();
    chk("prio_pre1", int'(o), int'(5'b00011));
    step();
    chk("prio_pre2", int'(o), int'(5'b00011));
    step();
    chk("prio_release_no_repeat", int'(o), int'(5'b01000));
    step();
    chk("prio_after", int'(o), 0);

    // Reset asserted while repeating with db high.
    bif.db = 1'b1;
    w = 0;
    do begin step(); w++; end while (!bif.long_press && w < 40);
    chk("reach_repeating", int'(bif.long_press), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'(o), 0);
    @(negedge clk);
    chk("reset_hold_outputs", int'(o), 0);
    rst_n = 1'b1;
    step();
    chk("rst_rel_e0", int'(o), 0);
    step();
    chk("rst_rel_e1", int'(o), 0);
    step();
    chk("rst_rel_press", int'(o), int'(5'b10010));
    step();
    chk("rst_rel_e3", int'(o), int'(5'b00010));
    d = 1;
    while (!bif.repeat_evt && d < 20) begin step(); d++; end
    chk("rst_first_repeat_window", int'(d >= 9 && d <= 12), 1);
    bif.db = 1'b0;
    w = 0;
    do begin step(); w++; end while (!bif.release_evt && w < 6);
    chk("rst_seq_release", int'(bif.release_evt), 1);
    step();

    // Random stream, min level length 3.
    excl_viol = 0; alt_viol = 0; long_viol = 0;
    pc = 0; rc = 0; rptc = 0; last_ev = 2; ncyc = 0;
    while (ncyc < 10000) begin
      bif.db = ~bif.db;
      len = $urandom_range(3, 30);
      for (int k = 0; k < len; k++) begin
        step();
        ncyc++;
        if (int'(bif.press) + int'(bif.release_evt) + int'(bif.repeat_evt) > 1) excl_viol++;
        if (bif.long_press && !bif.held) long_viol++;
        if (bif.press) begin
          if (last_ev == 1) alt_viol++;
          last_ev = 1; pc++;
        end
        if (bif.release_evt) begin
          if (last_ev != 1) alt_viol++;
          last_ev = 2; rc++;
        end
        if (bif.repeat_evt) rptc++;
      end
    end
    bif.db = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bif.press) begin
        if (last_ev == 1) alt_viol++;
        last_ev = 1; pc++;
      end
      if (bif.release_evt) begin
        if (last_ev != 1) alt_viol++;
        last_ev = 2; rc++;
      end
    end
    chk("rand_exclusive", excl_viol, 0);
    chk("rand_alternate", alt_viol, 0);
    chk("rand_long_implies_held", long_viol, 0);
    chk("rand_balance", pc - rc, 0);
    chk("rand_presses_seen", int'(pc > 100), 1);
    chk("rand_repeats_seen", int'(rptc > 0), 1);
    chk("rand_final_idle", int'(o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
